cmm_sfifo_drain: RTL and testbench

Read-side drain engine for the team's synchronous FIFO, which uses a push/pop interface with zero read delay. It pops words from the FIFO and presents them on a registered valid/ready stream through a 2-entry output buffer (head + skid). fifo_pop depends only on registered state and fifo_empty; there is no combinational path from m_ready to fifo_pop. The block sits between a FIFO instance and any valid/ready consumer in the axi_ram datapath.

---
 rtl/cmm_pkg.sv | 10 +
 rtl/cmm_sfifo.sv | 50 +++++
 rtl/cmm_sfifo_drain.sv | 93 +++++++++
 tb/tb_cmm_sfifo_drain.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmm_pkg.sv
// Shared definitions for the cmm FIFO blocks: drain engine state encoding.
package cmm_pkg;

  typedef enum logic [1:0] {
    CMM_DRN_EMPTY = 2'd0,
    CMM_DRN_ONE   = 2'd1,
    CMM_DRN_TWO   = 2'd2
  } cmm_drn_state_t;

endpackage

// File: rtl/cmm_sfifo.sv
// Synchronous FIFO with push/pop interface and zero read delay: dout shows
// the head word combinationally whenever the FIFO is non-empty.
module cmm_sfifo #(
  parameter int C_AW = 3,
  parameter int C_DW = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic [C_DW-1:0] din,
  input  logic            pop,
  output logic [C_DW-1:0] dout,
  output logic            empty,
  output logic            full,
  output logic [C_AW:0]   count
);

  localparam int DEPTH = 1 << C_AW;

  logic [C_DW-1:0] mem [DEPTH];
  logic [C_AW-1:0] wr_ptr;
  logic [C_AW-1:0] rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = count[C_AW];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage array; written only on an accepted push, never reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{C_AW{1'b0}}, do_push} - {{C_AW{1'b0}}, do_pop};
    end
  end

endmodule

// File: rtl/cmm_sfifo_drain.sv
// Read-side drain engine: pops a zero-latency FIFO into a 2-entry (head+skid)
// buffer and presents a registered valid/ready stream. fifo_pop never depends
// on m_ready, so the consumer cannot create a combinational path into the FIFO.
module cmm_sfifo_drain
  import cmm_pkg::*;
#(
  parameter int C_DW = 32,
  parameter int C_CW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fifo_empty,
  input  logic [C_DW-1:0] fifo_dout,
  output logic            fifo_pop,
  output logic            m_valid,
  output logic [C_DW-1:0] m_data,
  input  logic            m_ready,
  input  logic            flush,
  output logic [1:0]      buf_cnt,
  output logic [C_CW-1:0] xfer_cnt
);

  cmm_drn_state_t  state;
  cmm_drn_state_t  state_nxt;
  logic [C_DW-1:0] head;
  logic [C_DW-1:0] head_nxt;
  logic [C_DW-1:0] skid;
  logic [C_DW-1:0] skid_nxt;
  logic            fire;

  assign fire     = m_valid & m_ready;
  assign fifo_pop = ~fifo_empty & ~flush & ~rst & (state != CMM_DRN_TWO);
  assign m_valid  = (state != CMM_DRN_EMPTY);
  assign m_data   = head;
  assign buf_cnt  = state;

  // Next buffer state: flush wins, otherwise fill head first, then skid,
  // and refill head from skid when the consumer takes a beat.
  always_comb begin
    state_nxt = state;
    head_nxt  = head;
    skid_nxt  = skid;
    if (flush) begin
      state_nxt = CMM_DRN_EMPTY;
    end else begin
      case (state)
        CMM_DRN_EMPTY: begin
          if (fifo_pop) begin
            state_nxt = CMM_DRN_ONE;
            head_nxt  = fifo_dout;
          end
        end
        CMM_DRN_ONE: begin
          if (fifo_pop && fire) begin
            head_nxt = fifo_dout;
          end else if (fifo_pop) begin
            state_nxt = CMM_DRN_TWO;
            skid_nxt  = fifo_dout;
          end else if (fire) begin
            state_nxt = CMM_DRN_EMPTY;
          end
        end
        CMM_DRN_TWO: begin
          if (fire) begin
            state_nxt = CMM_DRN_ONE;
            head_nxt  = skid;
          end
        end
        default: state_nxt = CMM_DRN_EMPTY;
      endcase
    end
  end

  // State and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CMM_DRN_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      skid  <= skid_nxt;
    end
  end

  // Completed-beat counter; wraps naturally and survives flush.
  always_ff @(posedge clk) begin
    if (rst) xfer_cnt <= '0;
    else if (fire) xfer_cnt <= xfer_cnt + 1'b1;
  end

endmodule

// File: tb/tb_cmm_sfifo_drain.sv
// Bench for cmm_sfifo_drain paired with a real cmm_sfifo; table vectors,
// directed corner sequences and random traffic against a queue-based model.
module tb_cmm_sfifo_drain;

  localparam int DW    = 32;
  localparam int CW    = 4;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          m_ready;
  logic          fifo_push;
  logic [DW-1:0] fifo_din;
  logic [DW-1:0] fifo_dout;
  logic          fifo_empty;
  logic          fifo_full;
  logic          fifo_pop;
  logic [AW:0]   fifo_count;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [1:0]    buf_cnt;
  logic [CW-1:0] xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: words in the FIFO, words buffered for the stream, beats.
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] buf_q[$];
  logic [DW-1:0] got_q[$];
  int            mdl_xfer = 0;

  typedef struct {
    logic        push;
    logic [31:0] din;
    logic        ready;
    logic        valid;
    logic        chk_data;
    logic [31:0] data;
    logic [1:0]  cnt;
    logic        pop;
    logic [3:0]  xfer;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  cmm_sfifo #(.C_AW(AW), .C_DW(DW)) u_fifo (
    .clk   (clk),
    .rst_n (~rst),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  cmm_sfifo_drain #(.C_DW(DW), .C_CW(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready),
    .flush      (flush),
    .buf_cnt    (buf_cnt),
    .xfer_cnt   (xfer_cnt)
  );

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic p, input logic [31:0] d, input logic r,
                               input logic f, input logic rs);
    fifo_push = p;
    fifo_din  = d;
    m_ready   = r;
    flush     = f;
    rst       = rs;
  endtask

  // Compare DUT outputs with the model's view of the current cycle.
  task automatic checkOutput();
    bit exp_pop;
    exp_pop = !rst && !flush && (fifo_q.size() > 0) && (buf_q.size() < 2);
    checkVal("m_valid", {31'b0, m_valid}, {31'b0, buf_q.size() > 0});
    checkVal("buf_cnt", {30'b0, buf_cnt}, buf_q.size());
    checkVal("fifo_pop", {31'b0, fifo_pop}, {31'b0, exp_pop});
    checkVal("xfer_cnt", {28'b0, xfer_cnt}, mdl_xfer);
    if (buf_q.size() > 0) checkVal("m_data", m_data, buf_q[0]);
  endtask

  // Advance the model across the clock edge using the inputs just applied.
  task automatic updateModel();
    bit pop_e, fire_e, full_e;
    logic [DW-1:0] w;
    full_e = (fifo_q.size() == DEPTH);
    if (rst) begin
      fifo_q.delete();
      buf_q.delete();
      mdl_xfer = 0;
      return;
    end
    pop_e  = !flush && (fifo_q.size() > 0) && (buf_q.size() < 2);
    fire_e = (buf_q.size() > 0) && m_ready;
    if (fire_e) begin
      void'(buf_q.pop_front());
      mdl_xfer = (mdl_xfer + 1) % (1 << CW);
    end
    if (flush) buf_q.delete();
    else if (pop_e) begin
      w = fifo_q.pop_front();
      buf_q.push_back(w);
    end
    if (fifo_push && !full_e) fifo_q.push_back(fifo_din);
  endtask

  task automatic cycle(input bit chk);
    @(negedge clk);
    if (chk) checkOutput();
    if (m_valid && m_ready && !rst) got_q.push_back(m_data);
    @(posedge clk);
    #1;
    updateModel();
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0);
    cycle(1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] saved_xfer;
    logic [31:0] prev_data;
    bit          prev_hold;

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    updateModel();
    doReset();

    // Reset state.
    @(negedge clk);
    checkVal("rst_m_valid", {31'b0, m_valid}, 32'd0);
    checkVal("rst_buf_cnt", {30'b0, buf_cnt}, 32'd0);
    checkVal("rst_xfer_cnt", {28'b0, xfer_cnt}, 32'd0);
    checkVal("rst_m_data", m_data, 32'd0);
    checkVal("rst_fifo_pop", {31'b0, fifo_pop}, 32'd0);
    @(posedge clk);
    #1;
    updateModel();

    // Table: three words streamed back to back with m_ready high.
    vecs[0] = '{1'b1, 32'h11, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 4'd0};
    vecs[1] = '{1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b1, 4'd0};
    vecs[2] = '{1'b1, 32'h33, 1'b1, 1'b1, 1'b1, 32'h11, 2'd1, 1'b1, 4'd0};
    vecs[3] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h22, 2'd1, 1'b1, 4'd1};
    vecs[4] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 32'h33, 2'd1, 1'b0, 4'd2};
    vecs[5] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0, 1'b0, 4'd3};
    for (int i = 0; i < 6; i++) begin
      applyStimulus(vecs[i].push, vecs[i].din, vecs[i].ready, 1'b0, 1'b0);
      @(negedge clk);
      checkVal($sformatf("t1_valid[%0d]", i), {31'b0, m_valid}, {31'b0, vecs[i].valid});
      checkVal($sformatf("t1_cnt[%0d]", i), {30'b0, buf_cnt}, {30'b0, vecs[i].cnt});
      checkVal($sformatf("t1_pop[%0d]", i), {31'b0, fifo_pop}, {31'b0, vecs[i].pop});
      checkVal($sformatf("t1_xfer[%0d]", i), {28'b0, xfer_cnt}, {28'b0, vecs[i].xfer});
      if (vecs[i].chk_data) checkVal($sformatf("t1_data[%0d]", i), m_data, vecs[i].data);
      @(posedge clk);
      #1;
      updateModel();
    end

    // Backpressure: four words with m_ready low fill head+skid, two stay queued.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hA0 + i, 1'b0, 1'b0, 1'b0);
      cycle(1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("t2_buf_full", {30'b0, buf_cnt}, 32'd2);
    checkVal("t2_pop_low", {31'b0, fifo_pop}, 32'd0);
    checkVal("t2_fifo_left", {28'b0, fifo_count}, 32'd2);
    checkVal("t2_head", m_data, 32'hA0);
    @(posedge clk);
    #1;
    updateModel();
    got_q.delete();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cycle(1'b1);
    checkVal("t2_beats", got_q.size(), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      checkVal($sformatf("t2_order[%0d]", i), got_q[i], 32'hA0 + i);
    @(negedge clk);
    checkVal("t2_drained", {30'b0, buf_cnt}, 32'd0);
    @(posedge clk);
    #1;
    updateModel();

    // Toggled m_ready with eight words; data must hold while stalled.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 32'hB0 + i, 1'b0, 1'b0, 1'b0);
      cycle(1'b1);
    end
    got_q.delete();
    prev_hold = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 40 && got_q.size() < 8; i++) begin
      applyStimulus(1'b0, 32'h0, i[0], 1'b0, 1'b0);
      @(negedge clk);
      checkOutput();
      if (prev_hold) checkVal("t3_stable", m_data, prev_data);
      prev_hold = m_valid && !m_ready;
      prev_data = m_data;
      if (m_valid && m_ready) got_q.push_back(m_data);
      @(posedge clk);
      #1;
      updateModel();
    end
    checkVal("t3_beats", got_q.size(), 32'd8);
    for (int i = 0; i < 8 && i < got_q.size(); i++)
      checkVal($sformatf("t3_order[%0d]", i), got_q[i], 32'hB0 + i);

    // Flush with head+skid holding 0xA,0xB and 0xC still in the FIFO.
    applyStimulus(1'b1, 32'hA, 1'b0, 1'b0, 1'b0); cycle(1'b1);
    applyStimulus(1'b1, 32'hB, 1'b0, 1'b0, 1'b0); cycle(1'b1);
    applyStimulus(1'b1, 32'hC, 1'b0, 1'b0, 1'b0); cycle(1'b1);
    saved_xfer = mdl_xfer;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkVal("t4_pre_cnt", {30'b0, buf_cnt}, 32'd2);
    checkVal("t4_pre_head", m_data, 32'hA);
    checkVal("t4_pre_fifo", {28'b0, fifo_count}, 32'd1);
    checkVal("t4_flush_pop", {31'b0, fifo_pop}, 32'd0);
    @(posedge clk);
    #1;
    updateModel();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("t4_post_cnt", {30'b0, buf_cnt}, 32'd0);
    checkVal("t4_post_valid", {31'b0, m_valid}, 32'd0);
    checkVal("t4_post_xfer", {28'b0, xfer_cnt}, saved_xfer);
    @(posedge clk);
    #1;
    updateModel();
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("t4_c_valid", {31'b0, m_valid}, 32'd1);
    checkVal("t4_c_data", m_data, 32'hC);
    @(posedge clk);
    #1;
    updateModel();
    cycle(1'b1);

    // Counter wrap: 17 beats from reset on a 4-bit counter leaves 1.
    doReset();
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 32'hD00 + i, 1'b1, 1'b0, 1'b0);
      cycle(1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1);
    @(negedge clk);
    checkVal("t5_wrap", {28'b0, xfer_cnt}, 32'd1);
    @(posedge clk);
    #1;
    updateModel();

    // Reset while the buffer is full and the consumer is ready.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hE0 + i, 1'b0, 1'b0, 1'b0);
      cycle(1'b1);
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      @(negedge clk);
      checkVal($sformatf("t6_rst_pop[%0d]", i), {31'b0, fifo_pop}, 32'd0);
      @(posedge clk);
      #1;
      updateModel();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkVal("t6_valid", {31'b0, m_valid}, 32'd0);
    checkVal("t6_cnt", {30'b0, buf_cnt}, 32'd0);
    checkVal("t6_xfer", {28'b0, xfer_cnt}, 32'd0);
    checkVal("t6_fifo", {28'b0, fifo_count}, 32'd0);
    @(posedge clk);
    #1;
    updateModel();

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(9) < 6), $urandom, ($urandom_range(1) == 1),
                    ($urandom_range(29) == 0), ($urandom_range(99) == 0));
      cycle(1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
